// File: rtl/ula_seq_pkg.sv
// Shared types and dual-rail helpers for the ULA operation sequencer.
// Pair layout: [1] = true rail, [0] = false rail; 00 NULL, 10 TRUE, 01 FALSE, 11 illegal.
package ula_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_NULL = 2'b10,
    S_RESP = 2'b11
  } state_e;

  localparam logic [1:0] DR_NULL  = 2'b00;
  localparam logic [1:0] DR_TRUE  = 2'b10;
  localparam logic [1:0] DR_FALSE = 2'b01;

  // Helpers work on the widest supported vector; callers size-cast in and slice out.
  localparam int MAX_W = 64;

  function automatic logic [2*MAX_W-1:0] dr_encode(input logic [MAX_W-1:0] v);
    logic [2*MAX_W-1:0] d;
    for (int i = 0; i < MAX_W; i++) d[2*i +: 2] = v[i] ? DR_TRUE : DR_FALSE;
    return d;
  endfunction

  function automatic logic [MAX_W-1:0] dr_decode(input logic [2*MAX_W-1:0] d);
    logic [MAX_W-1:0] v;
    for (int i = 0; i < MAX_W; i++) v[i] = d[2*i+1] & ~d[2*i];
    return v;
  endfunction

endpackage

// File: rtl/dr_completion.sv
// Completion detector over N dual-rail pairs: all one-hot, all NULL, or any 11.
module dr_completion #(
  parameter int N = 9
) (
  input  logic [2*N-1:0] pairs,
  output logic           allValid,
  output logic           allNull,
  output logic           anyIllegal
);

  always_comb begin
    allValid   = 1'b1;
    allNull    = 1'b1;
    anyIllegal = 1'b0;
    for (int i = 0; i < N; i++) begin
      allValid   = allValid & (pairs[2*i] ^ pairs[2*i+1]);
      allNull    = allNull & ~(pairs[2*i] | pairs[2*i+1]);
      anyIllegal = anyIllegal | (pairs[2*i] & pairs[2*i+1]);
    end
  end

endmodule

// File: rtl/ula_op_sequencer.sv
// Four-phase DATA/NULL sequencer for the dual-rail ULA and its overflow detector.
// Optional sticky overflow flag: define ULA_STICKY_OVF_EN.
module ula_op_sequencer
  import ula_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [2*WIDTH-1:0] alu_a_dr,
  output logic [2*WIDTH-1:0] alu_b_dr,
  output logic [1:0]         alu_sel0_dr,
  output logic [1:0]         alu_sel1_dr,
  input  logic [2*WIDTH-1:0] alu_res_dr,
  input  logic [1:0]         alu_ovf_dr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_ovf,
  output logic               rsp_err,
  output logic               busy
`ifdef ULA_STICKY_OVF_EN
  ,
  input  logic               ovf_clr,
  output logic               ovf_sticky
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] resQ;
  logic [1:0]         ovfQ;
  logic               allValid, allNull, anyIllegal;
  logic               settled;
  logic               errQ;
  logic [WIDTH-1:0]   resLatch;
  logic               ovfLatch;
  logic [2*MAX_W-1:0] aEnc, bEnc;
  logic [MAX_W-1:0]   resDec;
  logic               timedOut, respEnter, respErr;
  logic               unusedBits;

  assign aEnc       = dr_encode(MAX_W'(req_a));
  assign bEnc       = dr_encode(MAX_W'(req_b));
  assign resDec     = dr_decode((2*MAX_W)'(resQ));
  assign unusedBits = ^{aEnc, bEnc, resDec};

  // Sample the asynchronous ALU rails before any completion decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resQ <= '0;
      ovfQ <= DR_NULL;
    end else begin
      resQ <= alu_res_dr;
      ovfQ <= alu_ovf_dr;
    end
  end

  dr_completion #(.N(WIDTH + 1)) uCompletion (
    .pairs      ({resQ, ovfQ}),
    .allValid   (allValid),
    .allNull    (allNull),
    .anyIllegal (anyIllegal)
  );

  assign timedOut  = (cnt == CNT_W'(TIMEOUT));
  assign respEnter = (state == S_NULL) && (allNull || timedOut);
  assign respErr   = errQ || !allNull;
  // settled holds off acceptance until res_q has seen the ALU once after reset
  assign req_ready = (state == S_IDLE) && allNull && settled;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      settled     <= 1'b0;
      errQ        <= 1'b0;
      resLatch    <= '0;
      ovfLatch    <= 1'b0;
      alu_a_dr    <= '0;
      alu_b_dr    <= '0;
      alu_sel0_dr <= DR_NULL;
      alu_sel1_dr <= DR_NULL;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_ovf     <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      settled <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            alu_a_dr    <= aEnc[2*WIDTH-1:0];
            alu_b_dr    <= bEnc[2*WIDTH-1:0];
            alu_sel0_dr <= req_op[0] ? DR_TRUE : DR_FALSE;
            alu_sel1_dr <= req_op[1] ? DR_TRUE : DR_FALSE;
            errQ        <= 1'b0;
            resLatch    <= '0;
            ovfLatch    <= 1'b0;
            cnt         <= '0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (allValid || anyIllegal || timedOut) begin
            alu_a_dr    <= '0;
            alu_b_dr    <= '0;
            alu_sel0_dr <= DR_NULL;
            alu_sel1_dr <= DR_NULL;
            cnt         <= '0;
            state       <= S_NULL;
            // Completion takes priority over a coincident timeout
            if (allValid) begin
              resLatch <= resDec[WIDTH-1:0];
              ovfLatch <= ovfQ[1];
            end else begin
              errQ <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NULL: begin
          if (respEnter) begin
            errQ       <= respErr;
            rsp_valid  <= 1'b1;
            rsp_err    <= respErr;
            rsp_result <= respErr ? '0 : resLatch;
            rsp_ovf    <= respErr ? 1'b0 : ovfLatch;
            cnt        <= '0;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cnt       <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ULA_STICKY_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (respEnter && !respErr && ovfLatch) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Directed bench for ula_op_sequencer with a behavioural dual-rail ALU and response model.
module tb_ula_op_sequencer;

  localparam int W  = 8;
  localparam int TO = 15;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_op = 2'b00;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic [2*W-1:0] alu_a_dr, alu_b_dr;
  logic [1:0]     alu_sel0_dr, alu_sel1_dr;
  logic [2*W-1:0] aluRes;
  logic [1:0]     aluOvf;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_result;
  logic           rsp_ovf, rsp_err, busy;
`ifdef ULA_STICKY_OVF_EN
  logic           ovfClr = 1'b0;
  logic           ovfSticky;
  logic           stickyAtRsp;
`endif

  int total = 0;
  int bad   = 0;

  int          aluMode  = 0;  // 0 normal, 1 never completes, 2 stuck valid, 3 illegal on pair 3
  int          aluDelay = 0;
  logic [1:0]  curOp = '0;
  logic [W-1:0] curA = '0, curB = '0;
  exp_t        expQ[$];
  int          lastDataLen = 0;

  always #5 clk = ~clk;

  ula_op_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a_dr    (alu_a_dr),
    .alu_b_dr    (alu_b_dr),
    .alu_sel0_dr (alu_sel0_dr),
    .alu_sel1_dr (alu_sel1_dr),
    .alu_res_dr  (aluRes),
    .alu_ovf_dr  (aluOvf),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_ovf     (rsp_ovf),
    .rsp_err     (rsp_err),
    .busy        (busy)
`ifdef ULA_STICKY_OVF_EN
    ,
    .ovf_clr     (ovfClr),
    .ovf_sticky  (ovfSticky)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  function automatic logic [1:0] enc1(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = enc1(v[i]);
    return r;
  endfunction

  // Signed overflow from plain integer arithmetic; only ADD/SUB can overflow
  function automatic logic [W:0] refOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, s;
    logic [W-1:0] r;
    logic o;
    sa = $signed(a);
    sb = $signed(b);
    o  = 1'b0;
    case (op)
      2'b00:   begin s = sa + sb; r = a + b; o = (s > 127) || (s < -128); end
      2'b01:   begin s = sa - sb; r = a - b; o = (s > 127) || (s < -128); end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {o, r};
  endfunction

  // Behavioural ALU: NULL out for NULL in, computed codeword once every input pair is valid
  logic [2*W-1:0] idealRes;
  logic [1:0]     idealOvf;
  logic [2*W+1:0] pipe [0:3];
  logic [2*W+1:0] aluOut;

  always_comb begin
    logic ok;
    logic [W-1:0] a, b;
    logic [W:0] r;
    idealRes = '0;
    idealOvf = '0;
    ok = (alu_sel0_dr[0] ^ alu_sel0_dr[1]) && (alu_sel1_dr[0] ^ alu_sel1_dr[1]);
    a = '0;
    b = '0;
    for (int i = 0; i < W; i++) begin
      ok   = ok && (alu_a_dr[2*i] ^ alu_a_dr[2*i+1]) && (alu_b_dr[2*i] ^ alu_b_dr[2*i+1]);
      a[i] = alu_a_dr[2*i+1];
      b[i] = alu_b_dr[2*i+1];
    end
    if (ok) begin
      r = refOp({alu_sel1_dr[1], alu_sel0_dr[1]}, a, b);
      idealRes = enc(r[W-1:0]);
      idealOvf = enc1(r[W]);
    end
  end

  always @(posedge clk) begin
    pipe[0] <= {idealOvf, idealRes};
    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
  end

  always_comb begin
    aluOut = (aluDelay == 0) ? {idealOvf, idealRes} : pipe[aluDelay-1];
    {aluOvf, aluRes} = aluOut;
    case (aluMode)
      1: {aluOvf, aluRes} = '0;
      2: {aluOvf, aluRes} = {2'b01, enc(8'h55)};
      3: if (aluOut != '0) aluRes[7:6] = 2'b11;
      default: ;
    endcase
  end

  // Per-cycle compare: responses against the model queue, ALU drive against the request
  initial begin : compare
    logic prevValid;
    logic [W+1:0] held;
    int dataRun;
    exp_t e;
    prevValid = 1'b0;
    held = '0;
    dataRun = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prevValid) begin
        check("rsp_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("model_result", rsp_result, e.res);
          check("model_ovf", rsp_ovf, e.ovf);
          check("model_err", rsp_err, e.err);
        end
        held = {rsp_result, rsp_ovf, rsp_err};
      end else if (rsp_valid) begin
        check("rsp_stable", {rsp_result, rsp_ovf, rsp_err}, held);
      end
      prevValid = rsp_valid;
      if (alu_a_dr != '0) begin
        dataRun++;
        check("enc_a", alu_a_dr, enc(curA));
        check("enc_b", alu_b_dr, enc(curB));
        check("enc_sel", {alu_sel1_dr, alu_sel0_dr}, {enc1(curOp[1]), enc1(curOp[0])});
      end else begin
        check("null_drive", {alu_b_dr, alu_sel1_dr, alu_sel0_dr}, 0);
        if (dataRun != 0) lastDataLen = dataRun;
        dataRun = 0;
      end
    end
  end

  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int mode, input int dly, input int hold, output int lat,
                       output logic [W-1:0] gRes, output logic gOvf, output logic gErr);
    int n;
    exp_t e;
    logic [W:0] r;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    r = refOp(op, a, b);
    if (mode == 0) e = '{res: r[W-1:0], ovf: r[W], err: 1'b0};
    else e = '{res: '0, ovf: 1'b0, err: 1'b1};
    expQ.push_back(e);
    curOp = op; curA = a; curB = b;
    aluMode = mode; aluDelay = dly;
    rsp_ready = (hold == 0);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 100);
    check("rsp_arrive", rsp_valid, 1);
    gRes = rsp_result; gOvf = rsp_ovf; gErr = rsp_err;
`ifdef ULA_STICKY_OVF_EN
    stickyAtRsp = ovfSticky;
    ovfClr = 1'b0;
`endif
    aluMode = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("rsp_hold_valid", rsp_valid, 1);
      check("req_ready_hold", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop", rsp_valid, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, n;
    logic [W-1:0] gRes;
    logic gOvf, gErr;

    repeat (2) @(negedge clk);
    check("rst_a", alu_a_dr, 0);
    check("rst_b", alu_b_dr, 0);
    check("rst_sel", {alu_sel1_dr, alu_sel0_dr}, 0);
    check("rst_rsp", {rsp_valid, rsp_result, rsp_ovf, rsp_err}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // ADD overflow with zero-delay ALU
    runOp(2'b00, 8'h7F, 8'h01, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("add_latency", lat, 4);
    check("add_data_len", lastDataLen, 2);
    check("add_result", gRes, 8'h80);
    check("add_ovf", gOvf, 1);
    check("add_err", gErr, 0);

    runOp(2'b01, 8'h80, 8'h01, 0, 3, 0, lat, gRes, gOvf, gErr);
    check("sub_result", gRes, 8'h7F);
    check("sub_ovf", gOvf, 1);
    check("sub_latency_slow", lat > 4, 1);

    runOp(2'b10, 8'hF0, 8'h3C, 0, 3, 0, lat, gRes, gOvf, gErr);
    check("and_result", gRes, 8'h30);
    check("and_ovf", gOvf, 0);

    runOp(2'b11, 8'h0F, 8'hA0, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("or_result", gRes, 8'hAF);

    // ALU never completes: DATA times out after TIMEOUT+1 cycles
    runOp(2'b00, 8'h12, 8'h34, 1, 0, 0, lat, gRes, gOvf, gErr);
    check("to_data_len", lastDataLen, TO + 1);
    check("to_err", gErr, 1);
    check("to_result", gRes, 0);

    // ALU stuck non-NULL: NULL phase times out
    runOp(2'b00, 8'h01, 8'h02, 2, 0, 0, lat, gRes, gOvf, gErr);
    check("stuck_err", gErr, 1);
    check("stuck_result", gRes, 0);

    // Illegal codeword on result pair 3, then a clean operation
    runOp(2'b00, 8'h11, 8'h22, 3, 0, 0, lat, gRes, gOvf, gErr);
    check("ill_err", gErr, 1);
    runOp(2'b01, 8'h10, 8'h20, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("after_ill_result", gRes, 8'hF0);
    check("after_ill_ovf", gOvf, 0);
    check("after_ill_err", gErr, 0);

    // Response back-pressure for 10 cycles
    runOp(2'b00, 8'h40, 8'h40, 0, 0, 10, lat, gRes, gOvf, gErr);
    check("hold_result", gRes, 8'h80);
    check("hold_ovf", gOvf, 1);

    // Reset mid-DATA with a slow ALU: abort, then stale ALU output blocks acceptance
    aluDelay = 3;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    curOp = 2'b00; curA = 8'h05; curB = 8'h06;
    req_op = 2'b00; req_a = 8'h05; req_b = 8'h06; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_a", alu_a_dr, 0);
    check("arst_b", alu_b_dr, 0);
    check("arst_sel", {alu_sel1_dr, alu_sel0_dr}, 0);
    check("arst_rsp", {rsp_valid, rsp_result, rsp_ovf, rsp_err}, 0);
    check("arst_busy", busy, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stale_block", req_ready, 0);
    n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_null", req_ready, 1);
    check("alu_null_at_ready", aluRes, 0);
    aluDelay = 0;
    runOp(2'b10, 8'hCC, 8'hAA, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("post_rst_result", gRes, 8'h88);

`ifdef ULA_STICKY_OVF_EN
    @(negedge clk);
    ovfClr = 1'b1;
    @(posedge clk);
    #1 ovfClr = 1'b0;
    check("sticky_clr0", ovfSticky, 0);
    runOp(2'b00, 8'h7F, 8'h01, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("sticky_set", stickyAtRsp, 1);
    runOp(2'b10, 8'hF0, 8'h3C, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("sticky_keep", ovfSticky, 1);
    ovfClr = 1'b1;
    runOp(2'b01, 8'h80, 8'h01, 0, 0, 0, lat, gRes, gOvf, gErr);
    check("sticky_set_wins", stickyAtRsp, 1);
    @(negedge clk);
    ovfClr = 1'b1;
    @(posedge clk);
    #1 ovfClr = 1'b0;
    check("sticky_clr1", ovfSticky, 0);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
